tmds_rx_channel: RTL and testbench



---
 rtl/tmds_pkg.sv | 39 +++
 rtl/tmds_symbol_decode.sv | 42 ++++
 rtl/tmds_rx_channel.sv | 158 +++++++++++++++
 tb/tb_tmds_rx_channel.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared constants and types for the TMDS receive channel.
// TMDS_RX_TERC4_EN adds the TERC4 fields to the decoded-symbol payload.
package tmds_pkg;

  localparam int unsigned WORD_W = 10;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CTRL_W = 2;
  localparam int unsigned AUX_W  = 4;

  localparam logic [WORD_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [WORD_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [WORD_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [WORD_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    ST_SEARCH    = 2'd0,
    ST_SLIP_WAIT = 2'd1,
    ST_LOCKED    = 2'd2
  } state_t;

  // HDMI TERC4 codes indexed by the nibble they carry
  localparam logic [WORD_W-1:0] TERC4_CODES [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };

  typedef struct packed {
    logic              is_ctrl;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
`ifdef TMDS_RX_TERC4_EN
    logic              is_terc4;
    logic [AUX_W-1:0]  aux;
`endif
  } sym_t;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational classification and 10b->8b decode of one TMDS symbol.
// TMDS_RX_TERC4_EN enables TERC4 code recognition.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output sym_t              sym
);

  logic [DATA_W-1:0] q;
  logic [DATA_W-1:0] d;

  always_comb begin
    sym  = '0;
    q    = word[9] ? ~word[7:0] : word[7:0];
    d    = '0;
    d[0] = q[0];
    // bit 8 selects XOR vs XNOR chaining used by the encoder
    for (int i = 1; i < DATA_W; i++) begin
      d[i] = word[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    sym.data = d;

    case (word)
      CTRL_TOKEN_00: begin sym.is_ctrl = 1'b1; sym.ctrl = 2'b00; end
      CTRL_TOKEN_01: begin sym.is_ctrl = 1'b1; sym.ctrl = 2'b01; end
      CTRL_TOKEN_10: begin sym.is_ctrl = 1'b1; sym.ctrl = 2'b10; end
      CTRL_TOKEN_11: begin sym.is_ctrl = 1'b1; sym.ctrl = 2'b11; end
      default: ;
    endcase

`ifdef TMDS_RX_TERC4_EN
    for (int k = 0; k < 16; k++) begin
      if (word == TERC4_CODES[k]) begin
        sym.is_terc4 = 1'b1;
        sym.aux      = AUX_W'(k);
      end
    end
`endif
  end

endmodule

// File: rtl/tmds_rx_channel.sv
// One TMDS receive channel: word alignment via bitslip, lock tracking and symbol decode.
// TMDS_RX_TERC4_EN adds aux/ade outputs for HDMI data-island TERC4 symbols.
module tmds_rx_channel
  import tmds_pkg::*;
#(
  parameter int unsigned CTRL_RUN      = 8,
  parameter int unsigned SEARCH_WINDOW = 1024,
  parameter int unsigned SLIP_WAIT     = 16
) (
  input  logic              pixel_clk,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] tmds_word,
  output logic              bitslip,
  output logic              locked,
  output logic [3:0]        slip_cnt,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl,
  output logic              de
`ifdef TMDS_RX_TERC4_EN
  ,
  output logic [AUX_W-1:0]  aux,
  output logic              ade
`endif
);

  localparam int unsigned RUN_W  = $clog2(CTRL_RUN + 1);
  localparam int unsigned WIN_W  = $clog2(SEARCH_WINDOW + 1);
  localparam int unsigned WAIT_W = $clog2(SLIP_WAIT + 1);

  sym_t              sym;
  state_t            state, state_n;
  logic [RUN_W-1:0]  run_cnt, run_n;
  logic [WIN_W-1:0]  win_cnt, win_n;
  logic [WAIT_W-1:0] wait_cnt, wait_n;
  logic [3:0]        slip_n;
  logic              bitslip_n, locked_n, keepalive;

  tmds_symbol_decode u_decode (
    .word (tmds_word),
    .sym  (sym)
  );

  // Symbols that prove the link is still alive while locked
`ifdef TMDS_RX_TERC4_EN
  assign keepalive = sym.is_ctrl | sym.is_terc4;
`else
  assign keepalive = sym.is_ctrl;
`endif

  // Alignment FSM next-state logic
  always_comb begin
    state_n   = state;
    run_n     = run_cnt;
    win_n     = win_cnt;
    wait_n    = wait_cnt;
    slip_n    = slip_cnt;
    bitslip_n = 1'b0;
    locked_n  = locked;
    case (state)
      ST_SEARCH: begin
        wait_n = '0;
        if (sym.is_ctrl) begin
          run_n = run_cnt + RUN_W'(1);
          win_n = '0;
        end else begin
          run_n = '0;
          win_n = win_cnt + WIN_W'(1);
        end
        if (run_n == RUN_W'(CTRL_RUN)) begin
          state_n  = ST_LOCKED;
          locked_n = 1'b1;
          slip_n   = 4'd0;
          run_n    = '0;
          win_n    = '0;
        end else if (win_n == WIN_W'(SEARCH_WINDOW)) begin
          state_n   = ST_SLIP_WAIT;
          bitslip_n = 1'b1;
          slip_n    = (slip_cnt == 4'd9) ? 4'd0 : slip_cnt + 4'd1;
          run_n     = '0;
          win_n     = '0;
        end
      end
      ST_SLIP_WAIT: begin
        run_n  = '0;
        win_n  = '0;
        wait_n = wait_cnt + WAIT_W'(1);
        if (wait_n == WAIT_W'(SLIP_WAIT)) begin
          state_n = ST_SEARCH;
          wait_n  = '0;
        end
      end
      ST_LOCKED: begin
        run_n  = '0;
        wait_n = '0;
        win_n  = keepalive ? '0 : win_cnt + WIN_W'(1);
        if (win_n == WIN_W'(SEARCH_WINDOW)) begin
          state_n  = ST_SEARCH;
          locked_n = 1'b0;
          win_n    = '0;
        end
      end
      default: begin
        state_n  = ST_SEARCH;
        run_n    = '0;
        win_n    = '0;
        wait_n   = '0;
        locked_n = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs; data gating follows the lock state being entered
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_SEARCH;
      run_cnt  <= '0;
      win_cnt  <= '0;
      wait_cnt <= '0;
      slip_cnt <= 4'd0;
      bitslip  <= 1'b0;
      locked   <= 1'b0;
      data     <= '0;
      ctrl     <= '0;
      de       <= 1'b0;
`ifdef TMDS_RX_TERC4_EN
      aux      <= '0;
      ade      <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      run_cnt  <= run_n;
      win_cnt  <= win_n;
      wait_cnt <= wait_n;
      slip_cnt <= slip_n;
      bitslip  <= bitslip_n;
      locked   <= locked_n;
`ifdef TMDS_RX_TERC4_EN
      ade      <= 1'b0;
`endif
      if (sym.is_ctrl) begin
        de   <= 1'b0;
        data <= '0;
        ctrl <= sym.ctrl;
`ifdef TMDS_RX_TERC4_EN
      end else if (sym.is_terc4) begin
        de   <= 1'b0;
        data <= '0;
        aux  <= sym.aux;
        ade  <= 1'b1;
`endif
      end else begin
        de   <= locked_n;
        data <= locked_n ? sym.data : '0;
      end
    end
  end

endmodule

// File: tb/tb_tmds_rx_channel.sv
// Self-checking bench for tmds_rx_channel: lock, decode table, random traffic, lock loss, slip search, reset.
// Build with TMDS_RX_TERC4_EN to exercise the aux/ade outputs.
`timescale 1ns/1ps
module tb_tmds_rx_channel;

  logic       pixel_clk = 1'b0;
  logic       reset_n   = 1'b0;
  logic [9:0] tmds_word = 10'b1101010100;
  logic       bitslip, locked, de;
  logic [3:0] slip_cnt;
  logic [7:0] data;
  logic [1:0] ctrl;
`ifdef TMDS_RX_TERC4_EN
  logic [3:0] aux;
  logic       ade;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [9:0] TOK [4] = '{10'b1101010100, 10'b0010101011,
                                     10'b0101010100, 10'b1010101011};
  localparam logic [9:0] TERC [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

  tmds_rx_channel dut (
    .pixel_clk (pixel_clk),
    .reset_n   (reset_n),
    .tmds_word (tmds_word),
    .bitslip   (bitslip),
    .locked    (locked),
    .slip_cnt  (slip_cnt),
    .data      (data),
    .ctrl      (ctrl),
    .de        (de)
`ifdef TMDS_RX_TERC4_EN
    ,
    .aux       (aux),
    .ade       (ade)
`endif
  );

  always #5 pixel_clk = ~pixel_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [9:0] w);
    tmds_word = w;
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  // Reference TMDS encoder (no disparity tracking): mode[0]=XNOR chain, mode[1]=invert
  function automatic logic [9:0] enc(input logic [7:0] b, input logic [1:0] mode);
    logic [7:0] qm;
    qm[0] = b[0];
    for (int i = 1; i < 8; i++) qm[i] = mode[0] ? ~(qm[i-1] ^ b[i]) : (qm[i-1] ^ b[i]);
    return {mode[1], ~mode[0], mode[1] ? ~qm : qm};
  endfunction

  // Word seen by a deserializer whose boundary sits 'off' bits into a periodic token stream
  function automatic logic [9:0] rot(input logic [9:0] t, input int off);
    logic [9:0] r;
    for (int j = 0; j < 10; j++) r[j] = t[(off + j) % 10];
    return r;
  endfunction

  function automatic int tok_idx(input logic [9:0] w);
    for (int i = 0; i < 4; i++) if (w == TOK[i]) return i;
    return -1;
  endfunction

  function automatic int terc_idx(input logic [9:0] w);
    for (int i = 0; i < 16; i++) if (w == TERC[i]) return i;
    return -1;
  endfunction

  typedef struct {
    logic [9:0] word;
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;
  } vec_t;

  vec_t tbl [9];
  int   pulses [$];

  initial begin
    logic [1:0] last_ctrl;
    logic [7:0] b;
    logic [9:0] w;
    int off, lock_k, pre_lock_slip, wide, nslip, ti;
    logic prev_bs;

    tbl[0] = '{enc(8'h00, 2'b00), 1'b1, 8'h00, 2'b00};
    tbl[1] = '{enc(8'hFF, 2'b01), 1'b1, 8'hFF, 2'b00};
    tbl[2] = '{enc(8'h55, 2'b10), 1'b1, 8'h55, 2'b00};
    tbl[3] = '{enc(8'h10, 2'b11), 1'b1, 8'h10, 2'b00};
    tbl[4] = '{TOK[3],            1'b0, 8'h00, 2'b11};
    tbl[5] = '{TOK[1],            1'b0, 8'h00, 2'b01};
    tbl[6] = '{enc(8'h3C, 2'b00), 1'b1, 8'h3C, 2'b01};
    tbl[7] = '{TOK[2],            1'b0, 8'h00, 2'b10};
`ifdef TMDS_RX_TERC4_EN
    tbl[8] = '{TERC[10],          1'b0, 8'h00, 2'b10};
`else
    tbl[8] = '{TERC[10],          1'b1, 8'hA4, 2'b10};
`endif

    // Reset values
    #12;
    chk("rst_bitslip", 32'(bitslip), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_slip_cnt", 32'(slip_cnt), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_ctrl", 32'(ctrl), 32'd0);
    chk("rst_de", 32'(de), 32'd0);
`ifdef TMDS_RX_TERC4_EN
    chk("rst_ade", 32'(ade), 32'd0);
    chk("rst_aux", 32'(aux), 32'd0);
`endif
    reset_n = 1'b1;

    // Aligned token stream locks after the eighth token
    nslip = 0;
    for (int n = 1; n <= 20; n++) begin
      step(TOK[0]);
      if (bitslip) nslip++;
      if (n == 7) chk("lock_before_8th", 32'(locked), 32'd0);
      if (n == 8) chk("lock_at_8th", 32'(locked), 32'd1);
    end
    chk("aligned_ctrl", 32'(ctrl), 32'd0);
    chk("aligned_de", 32'(de), 32'd0);
    chk("aligned_data", 32'(data), 32'd0);
    chk("aligned_no_slip", 32'(nslip), 32'd0);

    // Decode table while locked
    foreach (tbl[i]) begin
      step(tbl[i].word);
      chk($sformatf("tbl%0d_de", i), 32'(de), 32'(tbl[i].de));
      chk($sformatf("tbl%0d_data", i), 32'(data), 32'(tbl[i].data));
      chk($sformatf("tbl%0d_ctrl", i), 32'(ctrl), 32'(tbl[i].ctrl));
`ifdef TMDS_RX_TERC4_EN
      if (i == 8) begin
        chk("terc4_ade", 32'(ade), 32'd1);
        chk("terc4_aux", 32'(aux), 32'hA);
      end else begin
        chk($sformatf("tbl%0d_ade", i), 32'(ade), 32'd0);
      end
`endif
    end
    last_ctrl = 2'b10;

    // Random traffic against the behavioural model
    nslip = 0;
    for (int n = 0; n < 300; n++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 9) == 0) w = TOK[$urandom_range(0, 3)];
      else                           w = enc(b, 2'($urandom));
      step(w);
      if (bitslip) nslip++;
      ti = tok_idx(w);
      if (ti >= 0) begin
        last_ctrl = 2'(ti);
        chk("rnd_tok_de", 32'(de), 32'd0);
        chk("rnd_tok_data", 32'(data), 32'd0);
`ifdef TMDS_RX_TERC4_EN
      end else if (terc_idx(w) >= 0) begin
        chk("rnd_terc_de", 32'(de), 32'd0);
        chk("rnd_terc_ade", 32'(ade), 32'd1);
        chk("rnd_terc_aux", 32'(aux), 32'(terc_idx(w)));
`endif
      end else begin
        chk("rnd_data_de", 32'(de), 32'd1);
        chk("rnd_data", 32'(data), 32'(b));
      end
      chk("rnd_ctrl", 32'(ctrl), 32'(last_ctrl));
    end
    chk("rnd_locked", 32'(locked), 32'd1);
    chk("rnd_no_slip", 32'(nslip), 32'd0);

    // 1024 data words after a token drop lock with no bitslip
    step(TOK[0]);
    nslip = 0;
    for (int n = 1; n <= 1024; n++) begin
      do begin
        b = 8'($urandom);
        w = enc(b, 2'($urandom));
      end while (tok_idx(w) >= 0 || terc_idx(w) >= 0);
      step(w);
      if (bitslip) nslip++;
      if (n == 1023) begin
        chk("loss_pre_locked", 32'(locked), 32'd1);
        chk("loss_pre_de", 32'(de), 32'd1);
        chk("loss_pre_data", 32'(data), 32'(b));
      end
      if (n == 1024) begin
        chk("loss_locked", 32'(locked), 32'd0);
        chk("loss_de", 32'(de), 32'd0);
        chk("loss_data", 32'(data), 32'd0);
      end
    end
    chk("loss_no_slip", 32'(nslip), 32'd0);

    // Token stream misaligned by 7 bits needs three slips
    do_reset();
    off = 7; lock_k = -1; pre_lock_slip = -1; wide = 0; prev_bs = 1'b0;
    pulses.delete();
    for (int k = 1; k <= 6000; k++) begin
      step(rot(TOK[0], off));
      if (bitslip) begin
        if (prev_bs) wide++;
        pulses.push_back(k);
        off = (off + 1) % 10;
      end
      prev_bs = bitslip;
      if (locked) begin
        lock_k = k;
        break;
      end
      pre_lock_slip = 32'(slip_cnt);
    end
    chk("search_pulse_count", 32'(pulses.size()), 32'd3);
    chk("search_pulse_width", 32'(wide), 32'd0);
    if (pulses.size() == 3) begin
      chk("search_first_pulse", 32'(pulses[0]), 32'd1024);
      chk("search_gap1", 32'(pulses[1] - pulses[0]), 32'd1040);
      chk("search_gap2", 32'(pulses[2] - pulses[1]), 32'd1040);
      chk("search_lock_cycle", 32'(lock_k), 32'(pulses[2] + 16 + 8));
    end
    chk("search_slip_cnt", 32'(pre_lock_slip), 32'd3);
    chk("search_locked", 32'(locked), 32'd1);
    chk("search_slip_cnt_cleared", 32'(slip_cnt), 32'd0);

    // Async reset while waiting after the fifth slip
    do_reset();
    step(TOK[3]);
    nslip = 0;
    for (int k = 1; k <= 6000 && nslip < 5; k++) begin
      step(enc(8'h00, 2'b00));
      if (bitslip) nslip++;
    end
    chk("rst5_slip_cnt", 32'(slip_cnt), 32'd5);
    chk("rst5_ctrl", 32'(ctrl), 32'd3);
    for (int k = 0; k < 3; k++) step(enc(8'h00, 2'b00));
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_bitslip", 32'(bitslip), 32'd0);
    chk("rst_mid_locked", 32'(locked), 32'd0);
    chk("rst_mid_slip_cnt", 32'(slip_cnt), 32'd0);
    chk("rst_mid_data", 32'(data), 32'd0);
    chk("rst_mid_ctrl", 32'(ctrl), 32'd0);
    chk("rst_mid_de", 32'(de), 32'd0);
    #1;
    reset_n = 1'b1;
    nslip = 0;
    for (int n = 1; n <= 8; n++) begin
      step(TOK[0]);
      if (bitslip) nslip++;
      chk("relock_slip_cnt", 32'(slip_cnt), 32'd0);
      if (n == 7) chk("relock_before", 32'(locked), 32'd0);
      if (n == 8) chk("relock_at_8th", 32'(locked), 32'd1);
    end
    chk("relock_no_slip", 32'(nslip), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
